mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 124 ++++++++++++
 tb/tb_mult_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential shift-add unsigned multiplier: N steps per operation, fixed latency,
// result registers hold until the next completion.
module mult_seq #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P,
    output logic           ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     mcand_q;
    logic [N-1:0]     acc_hi_q;
    logic [N-1:0]     mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [2*N-1:0]   p_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [N:0]       addend_d;
    logic [N:0]       sum_d;
    logic [2*N-1:0]   product_d;

    // One shift-add step: carry-kept add into the upper half, then {carry, acc_hi, mplier} >> 1.
    always_comb begin
        addend_d  = {(N+1){1'b0}};
        if (mplier_q[0]) begin
            addend_d = {1'b0, mcand_q};
        end else begin
            addend_d = {(N+1){1'b0}};
        end
        sum_d     = {1'b0, acc_hi_q} + addend_d;
        product_d = {sum_d, mplier_q[N-1:1]};
    end

    // Control FSM together with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= {N{1'b0}};
            acc_hi_q <= {N{1'b0}};
            mplier_q <= {N{1'b0}};
            cnt_q    <= {CW{1'b0}};
            p_q      <= {(2*N){1'b0}};
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_hi_q <= {N{1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_q <= product_d[2*N-1:N];
                    mplier_q <= product_d[N-1:0];
                    // Final step: publish the product directly from the step logic.
                    if (cnt_q == CW'(N-1)) begin
                        p_q     <= product_d;
                        ovf_q   <= |product_d[2*N-1:N];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_hi_q <= {N{1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq (N=16): expected products queued at start, checked at done.
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [31:0] P;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] p;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    mult_seq #(.N(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t m;
        m.p   = {16'd0, a} * {16'd0, b};
        m.ovf = |m.p[31:16];
        return m;
    endfunction

    // Drive start for one edge (t0); returns #1 after t0 with operands scrambled.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
    endtask

    // Counts edges after t0 until done (bounded); also counts busy samples from t0.
    task automatic wait_done(output int cyc, output int busy_cyc);
        busy_cyc = busy ? 1 : 0;
        cyc      = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = 16'h1111;
        B     = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, ovf, P} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b P=%h want all 0", busy, done, ovf, P);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        exp_t e;
        start_op(16'd3, 16'd5);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        total++;
        if (cyc !== 16) begin bad++; $display("FAIL basic_latency: got %0d want 16", cyc); end
        total++;
        if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 16", bc); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        total++;
        if (P !== 32'h0000000F || P !== e.p) begin bad++; $display("FAIL basic_P: got %h want %h", P, e.p); end
        total++;
        if (ovf !== e.ovf) begin bad++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
        total++;
        if (P !== e.p) begin bad++; $display("FAIL basic_P_hold: got %h want %h", P, e.p); end
    endtask

    task automatic test_products();
        logic [15:0] ta [0:6];
        logic [15:0] tb [0:6];
        int cyc, bc;
        exp_t e;
        ta[0] = 16'hFFFF; tb[0] = 16'hFFFF;
        ta[1] = 16'h1234; tb[1] = 16'h0000;
        ta[2] = 16'h8000; tb[2] = 16'h0002;
        for (int i = 3; i < 7; i++) begin
            ta[i] = 16'($urandom);
            tb[i] = 16'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(cyc, bc);
            e = exp_q.pop_front();
            total++;
            if (cyc !== 16) begin bad++; $display("FAIL prod%0d_latency: got %0d want 16", i, cyc); end
            total++;
            if (P !== e.p) begin bad++; $display("FAIL prod%0d_P: got %h want %h", i, P, e.p); end
            total++;
            if (ovf !== e.ovf) begin bad++; $display("FAIL prod%0d_ovf: got %b want %b", i, ovf, e.ovf); end
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL prod%0d_done_width: got %b want 0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        int k;
        exp_t e;
        start_op(16'd7, 16'd9);
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
            if (k == 4) begin
                start = 1'b1; A = 16'd2; B = 16'd2;
            end else if (k == 5) begin
                start = 1'b0; A = 16'h5555; B = 16'h0F0F;
            end else begin
                start = 1'b0;
            end
        end
        e = exp_q.pop_front();
        total++;
        if (k !== 16) begin bad++; $display("FAIL ignore_latency: got %0d want 16", k); end
        total++;
        if (P !== 32'd63 || P !== e.p) begin bad++; $display("FAIL ignore_P: got %h want %h", P, e.p); end
        @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ignore_no_restart: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_back_to_back();
        int k;
        exp_t e;
        start = 1'b1; A = 16'd10; B = 16'd10;
        exp_q.push_back(model(16'd10, 16'd10));
        @(posedge clk);
        #1;
        A = 16'd4; B = 16'd4;
        exp_q.push_back(model(16'd4, 16'd4));
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        e = exp_q.pop_front();
        total++;
        if (k !== 16) begin bad++; $display("FAIL b2b_first_latency: got %0d want 16", k); end
        total++;
        if (P !== 32'd100 || P !== e.p) begin bad++; $display("FAIL b2b_first_P: got %h want %h", P, e.p); end
        @(posedge clk);
        #1;
        k++;
        start = 1'b0; A = 16'hDEAD; B = 16'hBEEF;
        total++;
        if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_restart: got busy=%b done=%b want 1 0", busy, done); end
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 20) begin
                total++;
                if (P !== 32'd100) begin bad++; $display("FAIL b2b_P_hold: got %h want 00000064", P); end
            end
            if (done) break;
        end
        e = exp_q.pop_front();
        total++;
        if (k !== 33) begin bad++; $display("FAIL b2b_second_latency: got %0d want 33", k); end
        total++;
        if (P !== 32'd16 || P !== e.p) begin bad++; $display("FAIL b2b_second_P: got %h want %h", P, e.p); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int cyc, bc, done_seen;
        exp_t e;
        start_op(16'h00FF, 16'h0101);
        void'(exp_q.pop_back());
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, ovf, P} !== 35'd0) begin
            bad++;
            $display("FAIL async_rst_outputs: got busy=%b done=%b ovf=%b P=%h want all 0", busy, done, ovf, P);
        end
        #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        total++;
        if (done_seen !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_no_done: got done_pulses=%0d busy=%b want 0 0", done_seen, busy);
        end
        start_op(16'h0123, 16'h0456);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        total++;
        if (cyc !== 16 || P !== e.p) begin
            bad++;
            $display("FAIL after_rst_op: got cyc=%0d P=%h want cyc=16 P=%h", cyc, P, e.p);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
